// File: rtl/primitive_assembler_cull.sv
// Primitive assembly: walks the index buffer, fetches three vertices per triangle,
// converts to pixel/depth, computes a clamped bbox, culls, and emits over valid/ready.
module primitive_assembler_cull #(
  parameter int INPUT_VERTEX_DATAWIDTH       = 24,
  parameter int INPUT_VERTEX_FRACBITS        = 13,
  parameter int OUTPUT_VERTEX_DATAWIDTH      = 12,
  parameter int OUTPUT_VERTEX_DEPTH_FRACBITS = 12,
  parameter int MAX_TRIANGLE_COUNT           = 2048,
  parameter int SCREEN_WIDTH                 = 320,
  parameter int SCREEN_HEIGHT                = 320,
  localparam int TW = $clog2(MAX_TRIANGLE_COUNT),
  localparam int VW = $clog2(3*MAX_TRIANGLE_COUNT),
  localparam int IW = INPUT_VERTEX_DATAWIDTH,
  localparam int OW = OUTPUT_VERTEX_DATAWIDTH,
  localparam int DF = OUTPUT_VERTEX_DEPTH_FRACBITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  output logic                 ready,
  output logic                 finished,
  input  logic [TW-1:0]        i_num_triangles,
  input  logic [1:0]           i_cull_mode,
  output logic [TW-1:0]        o_triangle_addr,
  output logic                 o_triangle_read_en,
  input  logic [VW-1:0]        i_triangle_idx [3],
  output logic [VW-1:0]        o_vertex_addr,
  output logic                 o_vertex_read_en,
  input  logic signed [IW-1:0] i_vertex [3],
  input  logic                 i_vertex_invalid,
  output logic signed [OW-1:0] o_vertex_pixel [3][2],
  output logic [DF-1:0]        o_vertex_z [3],
  output logic signed [OW-1:0] bb_tl [2],
  output logic signed [OW-1:0] bb_br [2],
  output logic                 o_dv,
  input  logic                 i_ready,
  output logic [TW:0]          o_num_emitted,
  output logic [TW:0]          o_num_culled,
  output logic [3:0]           o_dbg_state
);

  // Handshake: a primitive transfers on a clock edge where o_dv && i_ready; while
  // o_dv is high and i_ready low, every primitive output is held unchanged.

  localparam int FRAC = INPUT_VERTEX_FRACBITS;
  localparam int AW   = 2*OW + 3;

  localparam logic signed [IW-1:0] PMAX_I = IW'((1 <<< (OW-1)) - 1);
  localparam logic signed [IW-1:0] PMIN_I = IW'(-(1 <<< (OW-1)));
  localparam logic signed [OW-1:0] PMAX_O = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] PMIN_O = {1'b1, {(OW-1){1'b0}}};
  localparam logic [IW-1:0]        Z_ONE  = IW'(1) << FRAC;
  localparam logic signed [OW-1:0] XMAX   = OW'(SCREEN_WIDTH - 1);
  localparam logic signed [OW-1:0] YMAX   = OW'(SCREEN_HEIGHT - 1);
  localparam logic signed [OW-1:0] ZERO   = '0;

  typedef enum logic [3:0] {
    S_IDLE, S_IDX, S_V0, S_V1, S_V2, S_CAP, S_SETUP, S_EMIT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [TW-1:0]        r_count;
  logic [1:0]           r_mode;
  logic [TW-1:0]        r_t;
  logic [TW-1:0]        r_taddr;
  logic [VW-1:0]        r_vaddr;
  logic [VW-1:0]        r_idx [3];
  logic signed [OW-1:0] r_cap_px [3][2];
  logic [DF-1:0]        r_cap_z [3];
  logic                 r_reject;

  logic signed [OW-1:0] w_conv_x, w_conv_y;
  logic [DF-1:0]        w_conv_z;
  logic signed [AW-1:0] w_x [3];
  logic signed [AW-1:0] w_y [3];
  logic signed [AW-1:0] w_area;
  logic signed [OW-1:0] w_minx, w_maxx, w_miny, w_maxy;
  logic                 w_reject;
  logic                 w_last;

  function automatic logic signed [OW-1:0] to_pixel(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] s;
    s = v >>> FRAC;
    if (s > PMAX_I)      return PMAX_O;
    else if (s < PMIN_I) return PMIN_O;
    else                 return s[OW-1:0];
  endfunction

  function automatic logic [DF-1:0] to_depth(input logic [IW-1:0] z);
    if (z[IW-1])         return '0;
    else if (z >= Z_ONE) return '1;
    else                 return z[FRAC-1 -: DF];
  endfunction

  function automatic logic signed [OW-1:0] min3(input logic signed [OW-1:0] a, b, c);
    logic signed [OW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [OW-1:0] max3(input logic signed [OW-1:0] a, b, c);
    logic signed [OW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [OW-1:0] clamp(input logic signed [OW-1:0] v,
                                                 input logic signed [OW-1:0] hi);
    if (v < ZERO)    return ZERO;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  always_comb begin
    w_conv_x = to_pixel(i_vertex[0]);
    w_conv_y = to_pixel(i_vertex[1]);
    w_conv_z = to_depth($unsigned(i_vertex[2]));
  end

  // Area is evaluated at full width so no pixel combination can overflow.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_x[k] = AW'(r_cap_px[k][0]);
      w_y[k] = AW'(r_cap_px[k][1]);
    end
    w_area = (w_x[1] - w_x[0]) * (w_y[2] - w_y[0]) - (w_x[2] - w_x[0]) * (w_y[1] - w_y[0]);
    w_minx = min3(r_cap_px[0][0], r_cap_px[1][0], r_cap_px[2][0]);
    w_maxx = max3(r_cap_px[0][0], r_cap_px[1][0], r_cap_px[2][0]);
    w_miny = min3(r_cap_px[0][1], r_cap_px[1][1], r_cap_px[2][1]);
    w_maxy = max3(r_cap_px[0][1], r_cap_px[1][1], r_cap_px[2][1]);
    w_reject = r_reject
            || (w_area == '0)
            || (r_mode == 2'b01 && w_area[AW-1])
            || (r_mode == 2'b10 && !w_area[AW-1] && w_area != '0)
            || (w_maxx < ZERO) || (w_minx > XMAX)
            || (w_maxy < ZERO) || (w_miny > YMAX);
    w_last = (r_t == r_count - TW'(1));
  end

  always_comb begin
    w_next             = r_state;
    ready              = 1'b0;
    finished           = 1'b0;
    o_dv               = 1'b0;
    o_triangle_read_en = 1'b0;
    o_vertex_read_en   = 1'b0;
    o_triangle_addr    = r_taddr;
    o_vertex_addr      = r_vaddr;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = (i_num_triangles == '0) ? S_DONE : S_IDX;
      end
      S_IDX: begin
        o_triangle_read_en = 1'b1;
        o_triangle_addr    = r_t;
        w_next             = S_V0;
      end
      S_V0: begin
        o_vertex_read_en = 1'b1;
        o_vertex_addr    = i_triangle_idx[0];
        w_next           = S_V1;
      end
      S_V1: begin
        o_vertex_read_en = 1'b1;
        o_vertex_addr    = r_idx[1];
        w_next           = S_V2;
      end
      S_V2: begin
        o_vertex_read_en = 1'b1;
        o_vertex_addr    = r_idx[2];
        w_next           = S_CAP;
      end
      S_CAP:   w_next = S_SETUP;
      S_SETUP: w_next = w_reject ? (w_last ? S_DONE : S_IDX) : S_EMIT;
      S_EMIT: begin
        o_dv = 1'b1;
        if (i_ready) w_next = w_last ? S_DONE : S_IDX;
      end
      S_DONE: begin
        finished = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_mode        <= '0;
      r_t           <= '0;
      r_taddr       <= '0;
      r_vaddr       <= '0;
      r_reject      <= 1'b0;
      o_num_emitted <= '0;
      o_num_culled  <= '0;
      for (int k = 0; k < 3; k++) begin
        r_idx[k]             <= '0;
        r_cap_px[k][0]       <= '0;
        r_cap_px[k][1]       <= '0;
        r_cap_z[k]           <= '0;
        o_vertex_pixel[k][0] <= '0;
        o_vertex_pixel[k][1] <= '0;
        o_vertex_z[k]        <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        bb_tl[k] <= '0;
        bb_br[k] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_count       <= i_num_triangles;
          r_mode        <= i_cull_mode;
          r_t           <= '0;
          o_num_emitted <= '0;
          o_num_culled  <= '0;
        end
        S_IDX: begin
          r_taddr  <= r_t;
          r_reject <= 1'b0;
        end
        S_V0: begin
          r_idx   <= i_triangle_idx;
          r_vaddr <= i_triangle_idx[0];
        end
        S_V1: begin
          r_vaddr        <= r_idx[1];
          r_cap_px[0][0] <= w_conv_x;
          r_cap_px[0][1] <= w_conv_y;
          r_cap_z[0]     <= w_conv_z;
          r_reject       <= r_reject | i_vertex_invalid;
        end
        S_V2: begin
          r_vaddr        <= r_idx[2];
          r_cap_px[1][0] <= w_conv_x;
          r_cap_px[1][1] <= w_conv_y;
          r_cap_z[1]     <= w_conv_z;
          r_reject       <= r_reject | i_vertex_invalid;
        end
        S_CAP: begin
          r_cap_px[2][0] <= w_conv_x;
          r_cap_px[2][1] <= w_conv_y;
          r_cap_z[2]     <= w_conv_z;
          r_reject       <= r_reject | i_vertex_invalid;
        end
        S_SETUP: begin
          o_vertex_pixel <= r_cap_px;
          o_vertex_z     <= r_cap_z;
          bb_tl[0]       <= clamp(w_minx, XMAX);
          bb_tl[1]       <= clamp(w_miny, YMAX);
          bb_br[0]       <= clamp(w_maxx, XMAX);
          bb_br[1]       <= clamp(w_maxy, YMAX);
          if (w_reject) begin
            o_num_culled <= o_num_culled + (TW+1)'(1);
            r_t          <= r_t + TW'(1);
          end
        end
        S_EMIT: if (i_ready) begin
          o_num_emitted <= o_num_emitted + (TW+1)'(1);
          r_t           <= r_t + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_primitive_assembler_cull.sv
// Randomized bench for primitive_assembler_cull with a behavioural triangle model
// and an expected-primitive queue checked every cycle o_dv is high.
module tb_primitive_assembler_cull;

  localparam int TW = 11;
  localparam int VW = 13;
  localparam int IW = 24;
  localparam int OW = 12;
  localparam int DF = 12;
  localparam int SCALE = 8192;

  logic                 clk, rstn, start, ready, finished;
  logic [TW-1:0]        i_num_triangles;
  logic [1:0]           i_cull_mode;
  logic [TW-1:0]        o_triangle_addr;
  logic                 o_triangle_read_en;
  logic [VW-1:0]        i_triangle_idx [3];
  logic [VW-1:0]        o_vertex_addr;
  logic                 o_vertex_read_en;
  logic signed [IW-1:0] i_vertex [3];
  logic                 i_vertex_invalid;
  logic signed [OW-1:0] o_vertex_pixel [3][2];
  logic [DF-1:0]        o_vertex_z [3];
  logic signed [OW-1:0] bb_tl [2];
  logic signed [OW-1:0] bb_br [2];
  logic                 o_dv, i_ready;
  logic [TW:0]          o_num_emitted, o_num_culled;
  logic [3:0]           o_dbg_state;

  primitive_assembler_cull dut (
    .clk(clk), .rstn(rstn), .start(start), .ready(ready), .finished(finished),
    .i_num_triangles(i_num_triangles), .i_cull_mode(i_cull_mode),
    .o_triangle_addr(o_triangle_addr), .o_triangle_read_en(o_triangle_read_en),
    .i_triangle_idx(i_triangle_idx), .o_vertex_addr(o_vertex_addr),
    .o_vertex_read_en(o_vertex_read_en), .i_vertex(i_vertex),
    .i_vertex_invalid(i_vertex_invalid), .o_vertex_pixel(o_vertex_pixel),
    .o_vertex_z(o_vertex_z), .bb_tl(bb_tl), .bb_br(bb_br), .o_dv(o_dv),
    .i_ready(i_ready), .o_num_emitted(o_num_emitted), .o_num_culled(o_num_culled),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories seen by the DUT ----------------
  int tri_mem [0:2047][0:2];
  int vx [0:6143];
  int vy [0:6143];
  int vz [0:6143];
  bit vinv [0:6143];

  always @(posedge clk) begin
    if (o_triangle_read_en)
      for (int k = 0; k < 3; k++) i_triangle_idx[k] <= VW'(tri_mem[o_triangle_addr][k]);
    if (o_vertex_read_en) begin
      i_vertex[0]      <= IW'(vx[o_vertex_addr]);
      i_vertex[1]      <= IW'(vy[o_vertex_addr]);
      i_vertex[2]      <= IW'(vz[o_vertex_addr]);
      i_vertex_invalid <= vinv[o_vertex_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [155:0] exp_q[$];
  int exp_emit, exp_cull;
  int ready_pct  = 100;
  int stall_left = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_pix(input int v);
    int q;
    q = (v >= 0) ? v / SCALE : -((-v + SCALE - 1) / SCALE);
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  function automatic int to_z(input int v);
    if (v < 0) return 0;
    if (v >= SCALE) return 4095;
    return v / 2;
  endfunction

  function automatic int clip(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic build_expected(input int n, input int mode);
    exp_q.delete();
    exp_emit = 0;
    exp_cull = 0;
    for (int t = 0; t < n; t++) begin
      int xs[3], ys[3], zs[3];
      bit bad;
      longint area;
      int minx, maxx, miny, maxy;
      bit cull;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
        int vi;
        vi = tri_mem[t][k];
        xs[k] = to_pix(vx[vi]);
        ys[k] = to_pix(vy[vi]);
        zs[k] = to_z(vz[vi]);
        bad |= vinv[vi];
      end
      area = longint'(xs[1] - xs[0]) * (ys[2] - ys[0]) - longint'(xs[2] - xs[0]) * (ys[1] - ys[0]);
      minx = xs[0]; maxx = xs[0]; miny = ys[0]; maxy = ys[0];
      for (int k = 1; k < 3; k++) begin
        if (xs[k] < minx) minx = xs[k];
        if (xs[k] > maxx) maxx = xs[k];
        if (ys[k] < miny) miny = ys[k];
        if (ys[k] > maxy) maxy = ys[k];
      end
      cull = bad || area == 0 || (mode == 1 && area < 0) || (mode == 2 && area > 0)
          || maxx < 0 || minx > 319 || maxy < 0 || miny > 319;
      if (cull) exp_cull++;
      else begin
        exp_emit++;
        exp_q.push_back({12'(xs[0]), 12'(ys[0]), 12'(xs[1]), 12'(ys[1]), 12'(xs[2]), 12'(ys[2]),
                         12'(zs[0]), 12'(zs[1]), 12'(zs[2]),
                         12'(clip(minx, 319)), 12'(clip(miny, 319)),
                         12'(clip(maxx, 319)), 12'(clip(maxy, 319))});
      end
    end
  endtask

  function automatic logic [155:0] obs_pack();
    return {o_vertex_pixel[0][0], o_vertex_pixel[0][1], o_vertex_pixel[1][0], o_vertex_pixel[1][1],
            o_vertex_pixel[2][0], o_vertex_pixel[2][1], o_vertex_z[0], o_vertex_z[1], o_vertex_z[2],
            bb_tl[0], bb_tl[1], bb_br[0], bb_br[1]};
  endfunction

  function automatic logic [255:0] all_outputs();
    return {obs_pack(), o_num_emitted, o_num_culled, finished, o_dv,
            o_triangle_read_en, o_vertex_read_en, o_triangle_addr, o_vertex_addr};
  endfunction

  // Downstream: chooses i_ready at each falling edge, then checks the held primitive.
  always @(negedge clk) begin
    if (rstn) begin
      if (stall_left > 0 && o_dv) begin
        i_ready = 1'b0;
        stall_left--;
      end else begin
        i_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (o_dv) begin
        check_val("dv_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check_val("primitive", obs_pack(), exp_q[0]);
          if (i_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_vtx(input int i, input int px, input int py, input int zr, input bit inv);
    vx[i] = px * SCALE;
    vy[i] = py * SCALE;
    vz[i] = zr;
    vinv[i] = inv;
  endtask

  task automatic set_tri(input int t, input int a, input int b, input int c);
    tri_mem[t][0] = a;
    tri_mem[t][1] = b;
    tri_mem[t][2] = c;
  endtask

  task automatic rand_model(input int n);
    for (int t = 0; t < n; t++)
      for (int k = 0; k < 3; k++) begin
        int vi;
        vi = int'($urandom_range(0, 6143));
        tri_mem[t][k] = vi;
        vx[vi] = (int'($urandom_range(0, 460)) - 60) * SCALE + int'($urandom_range(0, SCALE - 1));
        vy[vi] = (int'($urandom_range(0, 460)) - 60) * SCALE + int'($urandom_range(0, SCALE - 1));
        vz[vi] = int'($urandom_range(0, 12000)) - 2000;
        vinv[vi] = ($urandom_range(0, 9) == 0);
      end
  endtask

  task automatic run_model(input int n, input int mode, input bit busy_start,
                           output int dv_cyc, output int fin_cyc);
    int rd_cnt;
    int limit;
    build_expected(n, mode);
    dv_cyc  = -1;
    fin_cyc = -1;
    rd_cnt  = 0;
    limit   = 80 * n + 100;
    @(negedge clk);
    i_num_triangles = TW'(n);
    i_cull_mode     = 2'(mode);
    start           = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy_start && k == 3) begin
        start = 1'b1;
        i_num_triangles = TW'(n + 7);
      end
      if (busy_start && k == 4) start = 1'b0;
      if (o_triangle_read_en || o_vertex_read_en) rd_cnt++;
      if (o_dv && dv_cyc < 0) dv_cyc = k;
      if (finished) begin
        fin_cyc = k;
        break;
      end
    end
    check_val("finished_seen", (fin_cyc >= 0), 1);
    check_val("num_emitted", o_num_emitted, exp_emit);
    check_val("num_culled", o_num_culled, exp_cull);
    check_val("queue_drained", exp_q.size(), 0);
    if (n == 0) check_val("no_reads", rd_cnt, 0);
    @(negedge clk);
    check_val("fin_pulse_ready", {finished, ready}, 2'b01);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dvc, fnc;
    rstn = 1'b0;
    start = 1'b0;
    i_num_triangles = '0;
    i_cull_mode = '0;
    i_ready = 1'b0;
    i_vertex_invalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_triangle_idx[k] = '0;
      i_vertex[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_val("reset_outputs", all_outputs(), 0);
    check_val("reset_ready", ready, 1);
    rstn = 1'b1;
    @(negedge clk);
    check_val("idle_ready", ready, 1);

    // single triangle, timing and exact values
    set_vtx(0, 10, 10, 4096, 0);
    set_vtx(1, 50, 10, 4096, 0);
    set_vtx(2, 10, 50, 4096, 0);
    set_tri(0, 0, 1, 2);
    ready_pct = 100;
    run_model(1, 0, 0, dvc, fnc);
    check_val("first_dv_cycle", dvc, 7);
    check_val("finished_cycle", fnc, 8);

    // winding order against cull modes
    set_tri(0, 0, 2, 1);
    run_model(1, 1, 0, dvc, fnc);
    check_val("mode01_culled", o_num_culled, 1);
    run_model(1, 2, 0, dvc, fnc);
    check_val("mode10_emitted", o_num_emitted, 1);

    // collinear
    set_vtx(3, 0, 0, 100, 0);
    set_vtx(4, 5, 5, 100, 0);
    set_vtx(5, 9, 9, 100, 0);
    set_tri(0, 3, 4, 5);
    run_model(1, 0, 0, dvc, fnc);

    // bbox clamp and off-screen
    set_vtx(6, -20, -20, -50, 0);
    set_vtx(7, 400, 10, 9000, 0);
    set_vtx(8, 10, 400, 8191, 0);
    set_vtx(9, 330, 0, 10, 0);
    set_vtx(10, 400, 0, 10, 0);
    set_vtx(11, 330, 50, 10, 0);
    set_tri(0, 6, 7, 8);
    set_tri(1, 9, 10, 11);
    run_model(2, 0, 0, dvc, fnc);

    // invalid vertex on the middle triangle, downstream stall
    set_vtx(12, 20, 20, 1000, 0);
    set_vtx(13, 60, 20, 1000, 1);
    set_vtx(14, 20, 60, 1000, 0);
    set_tri(0, 0, 1, 2);
    set_tri(1, 12, 13, 14);
    set_tri(2, 6, 7, 8);
    stall_left = 5;
    ready_pct = 100;
    run_model(3, 0, 0, dvc, fnc);
    check_val("invalid_counts", {o_num_emitted, o_num_culled}, {12'd2, 12'd1});

    // empty model and start while busy
    run_model(0, 0, 0, dvc, fnc);
    check_val("empty_finish_cycle", fnc, 1);
    rand_model(4);
    ready_pct = 70;
    run_model(4, 0, 1, dvc, fnc);

    // random models
    for (int m = 0; m < 30; m++) begin
      int n;
      n = int'($urandom_range(1, 8));
      rand_model(n);
      ready_pct = int'($urandom_range(20, 100));
      run_model(n, int'($urandom_range(0, 3)), 0, dvc, fnc);
    end

    // reset while stalled in EMIT
    set_tri(0, 0, 1, 2);
    build_expected(1, 0);
    ready_pct = 0;
    @(negedge clk);
    i_num_triangles = TW'(1);
    i_cull_mode = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dvc = -1;
    for (int k = 0; k < 30; k++) begin
      if (o_dv) begin
        dvc = k;
        break;
      end
      @(negedge clk);
    end
    check_val("emit_reached", (dvc >= 0), 1);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_val("midreset_outputs", all_outputs(), 0);
    check_val("midreset_ready", ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ready_pct = 100;
    run_model(1, 0, 0, dvc, fnc);
    check_val("post_reset_dv_cycle", dvc, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
